// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bundle for conv_window_gen.
// master drives pixels and win_ready; slave is the window generator.
interface conv_window_gen_if #(
    parameter int N           = 5,
    parameter int C           = 1,
    parameter int F           = 3,
    parameter int S           = 1,
    parameter int indatawidth = 8
);
    localparam int PW = C * indatawidth;
    localparam int WW = F * F * PW;
    localparam int OW = (((N - F) / S + 1) > 1) ? $clog2((N - F) / S + 1) : 1;

    logic [PW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [WW-1:0] win_out;
    logic          win_valid;
    logic          win_ready;
    logic [OW-1:0] win_row;
    logic [OW-1:0] win_col;
    logic          frame_done;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_out, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_out, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// Raster pixel stream to F x F x C sliding windows (stride S, no padding).
// Keeps the last F image rows in a ring buffer and emits one packed window per handshake.
module conv_window_gen #(
    parameter int N           = 5,
    parameter int C           = 1,
    parameter int F           = 3,
    parameter int S           = 1,
    parameter int indatawidth = 8
) (
    input logic              clk,
    input logic              rst,
    conv_window_gen_if.slave bus
);
    localparam int PW = C * indatawidth;
    localparam int WW = F * F * PW;
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (F > 1) ? $clog2(F) : 1;
    localparam int SW = RW + 1;
    localparam int HW = (S > 1) ? $clog2(S) : 1;
    localparam int OW = (((N - F) / S + 1) > 1) ? $clog2((N - F) / S + 1) : 1;

    localparam logic [XW-1:0] LAST      = XW'(N - 1);
    localparam logic [XW-1:0] EDGE      = XW'(F - 1);
    localparam logic [HW-1:0] PH_LAST   = HW'(S - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(F - 1);

    logic [PW-1:0] mem_q [F][N];

    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] y_q, y_d;
    logic [HW-1:0] xph_q, xph_d;
    logic [HW-1:0] yph_q, yph_d;
    logic [OW-1:0] col_idx_q, col_idx_d;
    logic [OW-1:0] row_idx_q, row_idx_d;
    logic [RW-1:0] ring_q, ring_d;
    logic          win_valid_q, win_valid_d;
    logic [WW-1:0] win_out_q, win_out_d;
    logic [OW-1:0] win_row_q, win_row_d;
    logic [OW-1:0] win_col_q, win_col_d;
    logic          frame_done_q, frame_done_d;

    logic          pix_ready;
    logic          accept;
    logic          row_end;
    logic          frame_end;
    logic          win_fire;
    logic [SW-1:0] ring_sum [F];
    logic [RW-1:0] ring_sel [F];
    logic [XW-1:0] col_sel  [F];
    logic [WW-1:0] win_asm;

    assign pix_ready = !(win_valid_q && !bus.win_ready);
    assign accept    = bus.pix_valid && pix_ready;
    assign row_end   = (x_q == LAST);
    assign frame_end = row_end && (y_q == LAST);
    // Phase counters are zero exactly on stride-aligned window corners.
    assign win_fire  = accept && (x_q >= EDGE) && (y_q >= EDGE) &&
                       (xph_q == '0) && (yph_q == '0);

    // Window row r sits in ring slot (y + 1 + r) mod F; the newest row is ring_q.
    always_comb begin
        for (int r = 0; r < F; r++) begin
            ring_sum[r] = {1'b0, ring_q} + SW'(r + 1);
            ring_sel[r] = (ring_sum[r] >= SW'(F)) ? RW'(ring_sum[r] - SW'(F))
                                                  : RW'(ring_sum[r]);
        end
    end

    always_comb begin
        for (int c = 0; c < F; c++) begin
            col_sel[c] = x_q - XW'(F - 1 - c);
        end
    end

    // The bottom-right element is the pixel being accepted, not yet in storage.
    always_comb begin
        win_asm = '0;
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < F; c++) begin
                if (r == F - 1 && c == F - 1) begin
                    win_asm[(r * F + c) * PW +: PW] = bus.pix_in;
                end else begin
                    win_asm[(r * F + c) * PW +: PW] = mem_q[ring_sel[r]][col_sel[c]];
                end
            end
        end
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        xph_d     = xph_q;
        yph_d     = yph_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        ring_d    = ring_q;
        if (accept) begin
            if (row_end) begin
                x_d       = '0;
                xph_d     = '0;
                col_idx_d = '0;
                if (frame_end) begin
                    y_d       = '0;
                    yph_d     = '0;
                    row_idx_d = '0;
                    ring_d    = '0;
                end else begin
                    y_d    = y_q + 1'b1;
                    ring_d = (ring_q == RING_LAST) ? '0 : ring_q + 1'b1;
                    if (y_q >= EDGE) begin
                        if (yph_q == PH_LAST) begin
                            yph_d     = '0;
                            row_idx_d = row_idx_q + 1'b1;
                        end else begin
                            yph_d = yph_q + 1'b1;
                        end
                    end
                end
            end else begin
                x_d = x_q + 1'b1;
                if (x_q >= EDGE) begin
                    if (xph_q == PH_LAST) begin
                        xph_d     = '0;
                        col_idx_d = col_idx_q + 1'b1;
                    end else begin
                        xph_d = xph_q + 1'b1;
                    end
                end
            end
        end
    end

    // A window can only complete while the output slot is free or being drained,
    // because pix_ready is low whenever a held window is stalled.
    always_comb begin
        win_valid_d  = win_valid_q;
        win_out_d    = win_out_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = accept && frame_end;
        if (win_fire) begin
            win_valid_d = 1'b1;
            win_out_d   = win_asm;
            win_row_d   = row_idx_q;
            win_col_d   = col_idx_q;
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            xph_q        <= '0;
            yph_q        <= '0;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            ring_q       <= '0;
            win_valid_q  <= 1'b0;
            win_out_q    <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            xph_q        <= xph_d;
            yph_q        <= yph_d;
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
            ring_q       <= ring_d;
            win_valid_q  <= win_valid_d;
            win_out_q    <= win_out_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[ring_q][x_q] <= bus.pix_in;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win_out    = win_out_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: three configurations share one stimulus path,
// checked against an image-level window model with a pending-window queue.
module tb_conv_window_gen;
    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        pv;
    logic        wr;
    logic [15:0] pin;

    always #5 clk = ~clk;

    conv_window_gen_if #(.N(5), .C(1), .F(3), .S(1), .indatawidth(8)) bus_a ();
    conv_window_gen_if #(.N(5), .C(1), .F(3), .S(2), .indatawidth(8)) bus_b ();
    conv_window_gen_if #(.N(4), .C(2), .F(2), .S(1), .indatawidth(8)) bus_c ();

    assign bus_a.pix_valid = pv && (sel == 0);
    assign bus_a.pix_in    = pin[7:0];
    assign bus_a.win_ready = wr;
    assign bus_b.pix_valid = pv && (sel == 1);
    assign bus_b.pix_in    = pin[7:0];
    assign bus_b.win_ready = wr;
    assign bus_c.pix_valid = pv && (sel == 2);
    assign bus_c.pix_in    = pin;
    assign bus_c.win_ready = wr;

    conv_window_gen #(.N(5), .C(1), .F(3), .S(1), .indatawidth(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    conv_window_gen #(.N(5), .C(1), .F(3), .S(2), .indatawidth(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    conv_window_gen #(.N(4), .C(2), .F(2), .S(1), .indatawidth(8)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c));

    logic         o_pr, o_wv, o_fd;
    logic [127:0] o_win;
    int           o_row, o_col;

    always_comb begin
        o_pr  = bus_a.pix_ready;
        o_wv  = bus_a.win_valid;
        o_fd  = bus_a.frame_done;
        o_win = 128'(bus_a.win_out);
        o_row = int'(bus_a.win_row);
        o_col = int'(bus_a.win_col);
        if (sel == 1) begin
            o_pr  = bus_b.pix_ready;
            o_wv  = bus_b.win_valid;
            o_fd  = bus_b.frame_done;
            o_win = 128'(bus_b.win_out);
            o_row = int'(bus_b.win_row);
            o_col = int'(bus_b.win_col);
        end else if (sel == 2) begin
            o_pr  = bus_c.pix_ready;
            o_wv  = bus_c.win_valid;
            o_fd  = bus_c.frame_done;
            o_win = 128'(bus_c.win_out);
            o_row = int'(bus_c.win_row);
            o_col = int'(bus_c.win_col);
        end
    end

    typedef struct {
        logic [127:0] data;
        int           row;
        int           col;
    } win_t;

    win_t         exp_q[$];
    int           frame_vals[64];
    int           n_p, f_p, s_p, c_p;
    bit           exp_valid, exp_fd, got_first;
    logic [127:0] first_win;
    int           cur_idx, n_acc, fd_seen, fd_exp, win_cnt;
    int           n_cmp, n_bad;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int k);
        sel = k;
        n_p = (k == 2) ? 4 : 5;
        f_p = (k == 2) ? 2 : 3;
        s_p = (k == 1) ? 2 : 1;
        c_p = (k == 2) ? 2 : 1;
    endtask

    // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic step();
        int x, y;
        bit done_now;
        @(negedge clk);
        chk("pix_ready", o_pr, !(exp_valid && !wr));
        chk("win_valid", o_wv, exp_valid);
        chk("frame_done", o_fd, exp_fd);
        if (o_fd) fd_seen++;
        if (o_wv) begin
            chk("win_expected", 128'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("win_out", o_win, exp_q[0].data);
                chk("win_row", o_row, exp_q[0].row);
                chk("win_col", o_col, exp_q[0].col);
                if (wr) begin
                    if (!got_first) begin
                        first_win = o_win;
                        got_first = 1'b1;
                    end
                    void'(exp_q.pop_front());
                    win_cnt++;
                end
            end
        end
        done_now = 1'b0;
        exp_fd   = 1'b0;
        if (pv && o_pr) begin
            x = cur_idx % n_p;
            y = cur_idx / n_p;
            done_now = (x >= f_p - 1) && (y >= f_p - 1) &&
                       ((x - f_p + 1) % s_p == 0) && ((y - f_p + 1) % s_p == 0);
            if (cur_idx == n_p * n_p - 1) begin
                exp_fd = 1'b1;
                fd_exp++;
                cur_idx = 0;
            end else begin
                cur_idx++;
            end
            n_acc++;
        end
        exp_valid = done_now || (exp_valid && !wr);
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; 1: random gaps and ready; 2: 10-cycle stall on first window;
    // 3: ready until the last-but-one pixel, then stalled.
    task automatic run_frame(input int mode, input int stop_at, input bit rnd);
        int total, nw, cyc, hold_left;
        bit started;
        total = n_p * n_p;
        nw    = (n_p - f_p) / s_p + 1;
        for (int i = 0; i < total; i++) begin
            int v;
            v = rnd ? int'($urandom_range(255)) : i + 1;
            frame_vals[i] = (c_p == 2) ? (((v + 100) << 8) | v) : v;
        end
        for (int wy = 0; wy < nw; wy++) begin
            for (int wx = 0; wx < nw; wx++) begin
                win_t w;
                w.data = '0;
                for (int r = 0; r < f_p; r++) begin
                    for (int c = 0; c < f_p; c++) begin
                        logic [127:0] px;
                        px = 128'(frame_vals[(wy * s_p + r) * n_p + wx * s_p + c]);
                        w.data |= px << ((r * f_p + c) * c_p * 8);
                    end
                end
                w.row = wy;
                w.col = wx;
                exp_q.push_back(w);
            end
        end
        n_acc     = 0;
        cyc       = 0;
        hold_left = 10;
        started   = 1'b0;
        while (n_acc < stop_at && cyc < 1000) begin
            pv  = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
            pin = 16'(frame_vals[cur_idx]);
            case (mode)
                0: wr = 1'b1;
                1: wr = 1'($urandom_range(1));
                2: begin
                    if (o_wv) started = 1'b1;
                    if (started && hold_left > 0) begin
                        wr = 1'b0;
                        hold_left--;
                    end else begin
                        wr = 1'b1;
                    end
                end
                default: wr = (n_acc < stop_at - 1);
            endcase
            step();
            cyc++;
        end
        chk("frame_accepts", n_acc, stop_at);
    endtask

    task automatic drain();
        int cyc;
        pv  = 1'b0;
        wr  = 1'b1;
        cyc = 0;
        while ((exp_q.size() > 0 || exp_valid) && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        chk("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_bad = 0; fd_seen = 0; fd_exp = 0; win_cnt = 0;
        exp_valid = 1'b0; exp_fd = 1'b0; got_first = 1'b0; first_win = '0;
        cur_idx = 0; n_acc = 0;
        pv = 1'b0; wr = 1'b1; pin = '0; rst = 1'b1;
        set_cfg(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_win_valid", o_wv, 0);
        chk("rst_win_out", o_win, 0);
        chk("rst_win_row", o_row, 0);
        chk("rst_win_col", o_col, 0);
        chk("rst_frame_done", o_fd, 0);
        chk("rst_pix_ready", o_pr, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain stream, stride 1.
        got_first = 1'b0; win_cnt = 0;
        run_frame(0, 25, 1'b0);
        drain();
        chk("t1_first_win", first_win, 128'h0D0C0B080706030201);
        chk("t1_win_count", win_cnt, 9);

        // Backpressure on the first window.
        win_cnt = 0;
        run_frame(2, 25, 1'b0);
        drain();
        chk("bp_win_count", win_cnt, 9);

        // Three back-to-back random frames with gaps and random ready.
        win_cnt = 0;
        repeat (3) run_frame(1, 25, 1'b1);
        drain();
        chk("rnd_win_count", win_cnt, 27);

        // Reset mid-frame with a window pending.
        run_frame(3, 18, 1'b0);
        pv = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_win_valid", o_wv, 0);
        chk("rst_mid_pix_ready", o_pr, 1);
        exp_q.delete();
        exp_valid = 1'b0; exp_fd = 1'b0; cur_idx = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_first = 1'b0; win_cnt = 0;
        run_frame(0, 25, 1'b0);
        drain();
        chk("rst_first_win", first_win, 128'h0D0C0B080706030201);
        chk("rst_win_count", win_cnt, 9);

        // Stride 2.
        set_cfg(1);
        win_cnt = 0;
        run_frame(0, 25, 1'b0);
        drain();
        chk("s2_win_count", win_cnt, 4);

        // Two channels, F=2, N=4.
        set_cfg(2);
        got_first = 1'b0; win_cnt = 0;
        run_frame(0, 16, 1'b0);
        drain();
        chk("c2_first_win", first_win, 128'h6A06690566026501);
        chk("c2_win_count", win_cnt, 9);

        chk("frame_done_total", fd_seen, fd_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
